cmd_proc_q: RTL

Parametrised, queued successor to the robot command processor. It accepts CMD_W-bit route commands from the UART wrapper into a DEPTH-entry FIFO and consumes them as 2-bit fields at each line split. Each field produces a veer or a two-phase reverse, and the block chains commands back-to-back without stopping. Its `err_opn_lp` output feeds the PID open-line error mux, and `go` gates the motor drive. Bump handling resumes the interrupted manoeuvre instead of restarting it.

---
 rtl/cmd_proc_q.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cmd_proc_q.sv
// Queued robot command processor: buffers route commands in a FIFO and consumes them two bits per
// line split, driving motor enable and the open-loop steering error with resumable bump handling.
module cmd_proc_q #(
   parameter int unsigned CMD_W    = 16,
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] VEER_MAG = 16'h340,
   parameter logic [15:0] REV1_MAG = 16'h1E0,
   parameter logic [15:0] REV2_MAG = 16'h380,
   parameter logic [25:0] REV1_CYC = 26'd1441792,
   parameter logic [25:0] REV2_CYC = 26'd65011712,
   parameter logic [25:0] DBNC_CYC = 26'd4194304,
   parameter int unsigned BUZZ_BIT = 14
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CMD_W-1:0]         cmd,
   input  logic                     cmd_rdy,
   output logic                     clr_cmd_rdy,
   input  logic                     line_present,
   input  logic                     BMPL_n,
   input  logic                     BMPR_n,
   output logic                     go,
   output logic [15:0]              err_opn_lp,
   output logic                     buzz,
   output logic [$clog2(DEPTH):0]   q_cnt,
   output logic                     done
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [15:0] VEER_NEG = ~VEER_MAG + 16'd1;
   localparam logic [15:0] REV1_NEG = ~REV1_MAG + 16'd1;
   localparam logic [15:0] REV2_NEG = ~REV2_MAG + 16'd1;

   typedef enum logic [2:0] {
      StIdle, StFollow, StVeer, StRev1, StRev2, StReacq, StDbnc, StBump
   } state_e;

   state_e             state_q, state_d, ret_q, ret_d;
   logic [CMD_W-1:0]   shift_q, shift_d;
   logic               lvr_q, lvr_d;
   logic [25:0]        timer_q, timer_d, dbnc_q, dbnc_d;
   logic [BUZZ_BIT:0]  buzz_q, buzz_d;
   logic               done_q, done_d;
   logic [CMD_W-1:0]   mem_q [DEPTH];
   logic [PW-1:0]      wr_q, rd_q;
   logic [CW-1:0]      cnt_q;
   logic               push, pop, bumped, released;
   logic [1:0]         field;
   logic [25:0]        timer_inc;

   assign push        = cmd_rdy && (cnt_q < CW'(DEPTH));
   assign clr_cmd_rdy = push;
   assign field       = shift_q[1:0];
   assign bumped      = !BMPL_n || !BMPR_n;
   assign released    = BMPL_n && BMPR_n;
   assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 26'd1;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      shift_d = shift_q;
      lvr_d   = lvr_q;
      timer_d = timer_q;
      dbnc_d  = '0;
      buzz_d  = '0;
      done_d  = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cnt_q != '0 && line_present) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_q];
               state_d = StFollow;
            end
         end
         StDbnc: begin
            buzz_d = buzz_q + 1'b1;
            if (dbnc_q == DBNC_CYC - 26'd1) begin
               if (released) begin
                  state_d = ret_q;
                  buzz_d  = '0;
               end else begin
                  state_d = StBump;
               end
            end else begin
               dbnc_d = dbnc_q + 26'd1;
            end
         end
         StBump: begin
            buzz_d = buzz_q + 1'b1;
            if (released) begin
               state_d = ret_q;
               buzz_d  = '0;
            end
         end
         default: begin
            // Bump pre-empts everything; the phase timer simply holds while away.
            if (bumped) begin
               ret_d   = state_q;
               state_d = StDbnc;
            end else begin
               case (state_q)
                  StFollow: begin
                     if (!line_present) begin
                        case (field)
                           2'b00: begin
                              if (cnt_q != '0) begin
                                 pop     = 1'b1;
                                 shift_d = mem_q[rd_q];
                              end else begin
                                 state_d = StIdle;
                                 done_d  = 1'b1;
                              end
                           end
                           2'b11: begin
                              state_d = StRev1;
                              timer_d = '0;
                           end
                           default: state_d = StVeer;
                        endcase
                     end
                  end
                  StVeer: begin
                     if (line_present) begin
                        lvr_d   = (field == 2'b01);
                        shift_d = shift_q >> 2;
                        state_d = StFollow;
                     end
                  end
                  StRev1: begin
                     if (timer_q == REV1_CYC - 26'd1) begin
                        state_d = StRev2;
                        timer_d = '0;
                     end else begin
                        timer_d = timer_inc;
                     end
                  end
                  StRev2: begin
                     if (timer_q == REV2_CYC - 26'd1) state_d = StReacq;
                     else timer_d = timer_inc;
                  end
                  StReacq: begin
                     if (line_present) begin
                        shift_d = shift_q >> 2;
                        state_d = StFollow;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ret_q   <= StIdle;
         shift_q <= '0;
         lvr_q   <= 1'b0;
         timer_q <= '0;
         dbnc_q  <= '0;
         buzz_q  <= '0;
         done_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         shift_q <= shift_d;
         lvr_q   <= lvr_d;
         timer_q <= timer_d;
         dbnc_q  <= dbnc_d;
         buzz_q  <= buzz_d;
         done_q  <= done_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         if (push && !pop) cnt_q <= cnt_q + 1'b1;
         else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= cmd;
   end

   always_comb begin
      go         = 1'b0;
      err_opn_lp = '0;
      unique case (state_q)
         StFollow, StReacq: go = 1'b1;
         StVeer: begin
            go         = 1'b1;
            err_opn_lp = (field == 2'b01) ? VEER_MAG : VEER_NEG;
         end
         StRev1: begin
            go         = 1'b1;
            err_opn_lp = lvr_q ? REV1_MAG : REV1_NEG;
         end
         StRev2: begin
            go         = 1'b1;
            err_opn_lp = lvr_q ? REV2_NEG : REV2_MAG;
         end
         default: ;
      endcase
   end

   assign buzz  = buzz_q[BUZZ_BIT];
   assign q_cnt = cnt_q;
   assign done  = done_q;

endmodule
